// File: rtl/cvxif_dotp_pkg.sv
// Shared encodings and record types for the CV-X-IF int8 dot-product coprocessor.
package cvxif_dotp_pkg;

  localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
  localparam logic [6:0] FUNCT7_DOTP    = 7'b0000000;
  localparam logic [2:0] F3_DOTP        = 3'b000;
  localparam logic [2:0] F3_DOTPA       = 3'b001;
  localparam logic [2:0] F3_ACCRD       = 3'b010;

  localparam int unsigned LANES  = 4;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned DOT_W  = 18;

  typedef enum logic [1:0] {
    DOTP  = 2'd0,
    DOTPA = 2'd1,
    ACCRD = 2'd2
  } dotp_op_e;

  typedef struct packed {
    logic             valid;
    dotp_op_e         op;
    logic [4:0]       rd;
    logic [DOT_W-1:0] dot;
    logic             done;
    logic             committed;
    logic             killed;
  } slot_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } result_t;

endpackage

// File: rtl/cvxif_dotp_datapath.sv
// Two-stage int8x4 multiply-sum: S1 registers the four products, the sum is
// presented combinationally so the caller can register it as the second stage.
module cvxif_dotp_datapath
  import cvxif_dotp_pkg::*;
#(
  parameter int unsigned IdWidth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [31:0]             rs1_i,
  input  logic [31:0]             rs2_i,
  input  logic                    valid_i,
  input  logic [IdWidth-1:0]      id_i,
  output logic signed [DOT_W-1:0] dot_o,
  output logic                    valid_o,
  output logic [IdWidth-1:0]      id_o
);

  logic signed [PROD_W-1:0] prod_p1 [LANES];
  logic                     vld_p1;
  logic [IdWidth-1:0]       id_p1;

  function automatic logic signed [PROD_W-1:0] mul_s8(input logic signed [7:0] a,
                                                      input logic signed [7:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // S1: product registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= valid_i & ~flush_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i] <= mul_s8($signed(rs1_i[8*i +: 8]), $signed(rs2_i[8*i +: 8]));
      end
      id_p1 <= id_i;
    end
  end

  always_comb begin
    dot_o = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_o = dot_o + DOT_W'(prod_p1[i]);
    end
  end

  assign valid_o = vld_p1;
  assign id_o    = id_p1;

endmodule

// File: rtl/cvxif_dotp_unit.sv
// CV-X-IF coprocessor: decodes custom-3 dot-product ops, tracks them per id until
// commit, and retires them in issue order through one registered result port.
module cvxif_dotp_unit
  import cvxif_dotp_pkg::*;
#(
  parameter int unsigned IdWidth = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int unsigned        NSLOT = 2 ** IdWidth;
  localparam logic [IdWidth:0]   DEPTH = (IdWidth + 1)'(NSLOT);

  slot_t                   slot_q [NSLOT];
  logic [IdWidth-1:0]      fifo_q [NSLOT];
  logic [IdWidth-1:0]      wr_ptr_q, rd_ptr_q;
  logic [IdWidth:0]        cnt_q;
  logic                    fifo_full, fifo_empty;
  logic signed [XLEN-1:0]  acc_q, acc_nxt, acc_sum, dot_ext, wb_data;
  logic                    res_valid_q;
  logic [IdWidth-1:0]      res_id_q;
  result_t                 res_q;
  logic                    dec_hit;
  dotp_op_e                dec_op;
  slot_t                   alloc_slot;
  logic signed [DOT_W-1:0] dp_dot;
  logic                    dp_vld;
  logic [IdWidth-1:0]      dp_id;
  logic [IdWidth-1:0]      head_id;
  slot_t                   head_slot;
  logic                    commit_hit, cmt_now, head_cmt, head_kil;
  logic                    retire, retire_wb;
  logic                    instr_unused;

  function automatic logic signed [XLEN-1:0] sext_dot(input logic signed [DOT_W-1:0] d);
    return {{(XLEN - DOT_W){d[DOT_W-1]}}, d};
  endfunction

  assign instr_unused = ^issue_instr_i[24:15];

  always_comb begin
    dec_hit = 1'b0;
    dec_op  = DOTP;
    if (issue_instr_i[6:0] == OPCODE_CUSTOM3 && issue_instr_i[31:25] == FUNCT7_DOTP) begin
      case (issue_instr_i[14:12])
        F3_DOTP:  begin dec_hit = 1'b1; dec_op = DOTP;  end
        F3_DOTPA: begin dec_hit = 1'b1; dec_op = DOTPA; end
        F3_ACCRD: begin dec_hit = 1'b1; dec_op = ACCRD; end
        default:  dec_hit = 1'b0;
      endcase
    end
  end

  assign fifo_full         = (cnt_q == DEPTH);
  assign fifo_empty        = (cnt_q == '0);
  assign issue_ready_o     = ~slot_q[issue_id_i].valid & ~fifo_full & ~flush_i;
  assign issue_accept_o    = issue_valid_i & issue_ready_o & dec_hit;
  assign issue_writeback_o = issue_accept_o;

  always_comb begin
    alloc_slot       = '0;
    alloc_slot.valid = 1'b1;
    alloc_slot.op    = dec_op;
    alloc_slot.rd    = issue_instr_i[11:7];
  end

  cvxif_dotp_datapath #(.IdWidth(IdWidth)) u_datapath (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .rs1_i   (issue_rs1_i),
    .rs2_i   (issue_rs2_i),
    .valid_i (issue_accept_o),
    .id_i    (issue_id_i),
    .dot_o   (dp_dot),
    .valid_o (dp_vld),
    .id_o    (dp_id)
  );

  // A commit landing on the head in the retire cycle is forwarded so it retires at once.
  assign commit_hit = commit_valid_i & slot_q[commit_id_i].valid;
  assign head_id    = fifo_q[rd_ptr_q];
  assign head_slot  = slot_q[head_id];
  assign cmt_now    = commit_hit & (commit_id_i == head_id);
  assign head_cmt   = head_slot.committed | (cmt_now & ~commit_kill_i);
  assign head_kil   = head_slot.killed | (cmt_now & commit_kill_i);
  assign retire     = ~fifo_empty & head_slot.valid & head_slot.done & (head_cmt | head_kil)
                    & (~res_valid_q | result_ready_i) & ~flush_i;
  assign retire_wb  = retire & ~head_kil;

  always_comb begin
    dot_ext = sext_dot($signed(head_slot.dot));
    acc_sum = acc_q + dot_ext;
    wb_data = dot_ext;
    acc_nxt = acc_q;
    case (head_slot.op)
      DOTPA: begin
        wb_data = acc_sum;
        acc_nxt = acc_sum;
      end
      ACCRD: begin
        wb_data = acc_q;
        acc_nxt = '0;
      end
      default: begin
        wb_data = dot_ext;
        acc_nxt = acc_q;
      end
    endcase
  end

  // S2: the registered sum lands directly in its slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else begin
      if (dp_vld) begin
        slot_q[dp_id].dot  <= dp_dot;
        slot_q[dp_id].done <= 1'b1;
      end
      if (commit_hit) begin
        if (commit_kill_i) slot_q[commit_id_i].killed    <= 1'b1;
        else               slot_q[commit_id_i].committed <= 1'b1;
      end
      if (retire)         slot_q[head_id]    <= '0;
      if (issue_accept_o) slot_q[issue_id_i] <= alloc_slot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSLOT; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (issue_accept_o) begin
        fifo_q[wr_ptr_q] <= issue_id_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (retire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({issue_accept_o, retire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The accumulator survives a flush; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (retire_wb) begin
      acc_q <= acc_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_q       <= '0;
    end else if (flush_i) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_q       <= '0;
    end else if (retire_wb) begin
      res_valid_q <= 1'b1;
      res_id_q    <= head_id;
      res_q.data  <= wb_data;
      res_q.rd    <= head_slot.rd;
    end else if (result_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_data_o  = res_q.data;
  assign result_rd_o    = res_q.rd;
  assign result_we_o    = res_valid_q;

  commit_targets_live_slot: assert property (
    @(posedge clk_i) disable iff (!rst_ni) commit_valid_i |-> slot_q[commit_id_i].valid
  );

endmodule

// File: tb/tb_cvxif_dotp_unit.sv
// Scenario bench for cvxif_dotp_unit with an in-order result scoreboard.
module tb_cvxif_dotp_unit;

  logic        clk, rst_n, flush;
  logic        issue_valid, issue_ready, issue_accept, issue_wb;
  logic [31:0] issue_instr, issue_rs1, issue_rs2;
  logic [1:0]  issue_id, commit_id, result_id;
  logic        commit_valid, commit_kill;
  logic        result_valid, result_ready, result_we;
  logic [31:0] result_data;
  logic [4:0]  result_rd;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t               sb_q[$];
  int                 checks, errors;
  logic signed [31:0] acc_m;
  logic               hold_q;
  logic [31:0]        hold_data;
  logic [1:0]         hold_id;
  logic [4:0]         hold_rd;
  logic               s_acc, s_wb, s_rdy, s_rv;

  cvxif_dotp_unit #(.IdWidth(2), .XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] f7 = 7'd0,
                                           input logic [6:0] opc = 7'b1111011);
    return {f7, 10'd0, f3, rd, opc};
  endfunction

  function automatic logic signed [31:0] dot_m(input logic [31:0] a, input logic [31:0] b);
    int s;
    logic signed [7:0] x, y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  task automatic exp_push(input logic [2:0] f3, input logic [1:0] id,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic signed [31:0] d, v;
    d = dot_m(a, b);
    case (f3)
      3'b000:  v = d;
      3'b001:  begin acc_m = acc_m + d; v = acc_m; end
      default: begin v = acc_m; acc_m = 0; end
    endcase
    sb_q.push_back('{id: id, data: v, rd: rd});
  endtask

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic iv, input logic [31:0] instr, input logic [1:0] id,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic cv, input logic [1:0] cid, input logic ck,
                     output logic acc, output logic wb, output logic rdy, output logic rv);
    issue_valid = iv; issue_instr = instr; issue_id = id; issue_rs1 = a; issue_rs2 = b;
    commit_valid = cv; commit_id = cid; commit_kill = ck;
    #3;
    acc = issue_accept; wb = issue_wb; rdy = issue_ready; rv = result_valid;
    @(posedge clk); #1;
    issue_valid = 1'b0; commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results pending, want 0", name, sb_q.size());
      sb_q.delete();
    end
    idle(3);
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q = 1'b0;
      end else begin
        if (hold_q) begin
          checks++;
          if (result_valid !== 1'b1 || result_data !== hold_data || result_id !== hold_id ||
              result_rd !== hold_rd) begin
            errors++;
            $display("FAIL result_stable: got v=%0b id=%0d data=%h rd=%0d, want v=1 id=%0d data=%h rd=%0d",
                     result_valid, result_id, result_data, result_rd, hold_id, hold_data, hold_rd);
          end
        end
        if (result_valid && result_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got id=%0d data=%h, want no result", result_id, result_data);
          end else begin
            e = sb_q.pop_front();
            if (result_id !== e.id || result_data !== e.data || result_rd !== e.rd || result_we !== 1'b1) begin
              errors++;
              $display("FAIL result_payload: got id=%0d data=%h rd=%0d we=%0b, want id=%0d data=%h rd=%0d we=1",
                       result_id, result_data, result_rd, result_we, e.id, e.data, e.rd);
            end
          end
        end
        hold_q = result_valid && !result_ready;
        hold_data = result_data; hold_id = result_id; hold_rd = result_rd;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (issue_ready !== 1'b1 || issue_accept !== 1'b0 || issue_wb !== 1'b0 || result_valid !== 1'b0 ||
        result_we !== 1'b0 || result_data !== 32'h0 || result_id !== 2'd0 || result_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b acc=%0b wb=%0b rv=%0b we=%0b data=%h id=%0d rd=%0d, want rdy=1 rest 0",
               issue_ready, issue_accept, issue_wb, result_valid, result_we, result_data, result_id, result_rd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_dotp_basic();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    va = '{32'h02FF_0301, 32'h8080_8080, 32'h7F7F_7F7F};
    vb = '{32'h0405_0607, 32'h8080_8080, 32'h8080_8080};
    for (int i = 0; i < 3; i++) begin
      exp_push(3'b000, 2'(i), va[i], vb[i], 5'(5 + i));
      cyc(1, mk_instr(3'b000, 5'(5 + i)), 2'(i), va[i], vb[i], 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
      checks++;
      if (s_acc !== 1'b1 || s_wb !== 1'b1) begin
        errors++;
        $display("FAIL dotp_accept[%0d]: got accept=%0b wb=%0b, want 1 1", i, s_acc, s_wb);
      end
      if (i == 1) begin
        // commit arrives in the first retire cycle and must still make T+3
        idle(1);
        cyc(0, '0, '0, '0, '0, 1, 2'(i), 0, s_acc, s_wb, s_rdy, s_rv);
      end else begin
        cyc(0, '0, '0, '0, '0, 1, 2'(i), 0, s_acc, s_wb, s_rdy, s_rv);
        #2;
        checks++;
        if (result_valid !== 1'b0) begin
          errors++;
          $display("FAIL dotp_early[%0d]: got result_valid=%0b at T+2, want 0", i, result_valid);
        end
        @(posedge clk); #1;
      end
      #2;
      checks++;
      if (result_valid !== 1'b1) begin
        errors++;
        $display("FAIL dotp_latency[%0d]: got result_valid=%0b at T+3, want 1", i, result_valid);
      end
      @(posedge clk); #1;
      wait_drain("dotp_basic");
    end
  endtask

  task automatic test_dotpa_chain();
    logic [31:0] a, b;
    a = 32'h0101_0101; b = 32'h0202_0202;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_push(k == 3 ? 3'b010 : 3'b001, 2'(k), a, b, 5'(10 + k));
      cyc(k < 4, mk_instr(k == 3 ? 3'b010 : 3'b001, 5'(10 + k)), 2'(k), a, b,
          k > 0, 2'(k - 1), 0, s_acc, s_wb, s_rdy, s_rv);
      if (k < 4) begin
        checks++;
        if (s_acc !== 1'b1 || s_rdy !== 1'b1) begin
          errors++;
          $display("FAIL chain_accept[%0d]: got accept=%0b ready=%0b, want 1 1", k, s_acc, s_rdy);
        end
      end
    end
    wait_drain("dotpa_chain");
    exp_push(3'b010, 2'd0, '0, '0, 5'd20);
    cyc(1, mk_instr(3'b010, 5'd20), 2'd0, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    checks++;
    if (s_acc !== 1'b1) begin
      errors++;
      $display("FAIL accrd_accept: got %0b, want 1", s_acc);
    end
    cyc(0, '0, '0, '0, '0, 1, 2'd0, 0, s_acc, s_wb, s_rdy, s_rv);
    wait_drain("accrd_zero");
  endtask

  task automatic test_kill();
    logic [31:0] a, b;
    a = 32'h0101_0101; b = 32'h0202_0202;
    for (int k = 0; k < 4; k++) begin
      if (k < 3 && k != 1) exp_push(3'b001, 2'(k), a, b, 5'(1 + k));
      cyc(k < 3, mk_instr(3'b001, 5'(1 + k)), 2'(k), a, b,
          k > 0, 2'(k - 1), k == 2, s_acc, s_wb, s_rdy, s_rv);
    end
    exp_push(3'b010, 2'd3, '0, '0, 5'd9);
    cyc(1, mk_instr(3'b010, 5'd9), 2'd3, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    cyc(0, '0, '0, '0, '0, 1, 2'd3, 0, s_acc, s_wb, s_rdy, s_rv);
    wait_drain("kill");
  endtask

  task automatic test_backpressure();
    logic [31:0] a [4];
    logic [31:0] b [4];
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a[i] = $urandom; b[i] = $urandom; end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_push(3'b000, 2'(k), a[k], b[k], 5'(16 + k));
      cyc(k < 4, mk_instr(3'b000, 5'(16 + k)), 2'(k), k < 4 ? a[k] : '0, k < 4 ? b[k] : '0,
          k > 0, 2'(k - 1), 0, s_acc, s_wb, s_rdy, s_rv);
    end
    idle(1);
    for (int id = 1; id < 4; id++) begin
      cyc(0, '0, 2'(id), '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
      checks++;
      if (s_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low[id%0d]: got issue_ready=%0b, want 0", id, s_rdy);
      end
    end
    idle(1);
    checks++;
    if (result_valid !== 1'b1 || result_id !== 2'd0) begin
      errors++;
      $display("FAIL bp_head: got valid=%0b id=%0d, want valid=1 id=0", result_valid, result_id);
    end
    result_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3];
    int seen;
    bad = '{mk_instr(3'b011, 5'd3), mk_instr(3'b000, 5'd3, 7'd1), mk_instr(3'b000, 5'd3, 7'd0, 7'b0110011)};
    for (int i = 0; i < 3; i++) begin
      cyc(1, bad[i], 2'(i), 32'h0101_0101, 32'h0101_0101, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
      checks++;
      if (s_acc !== 1'b0 || s_wb !== 1'b0) begin
        errors++;
        $display("FAIL illegal_accept[%0d]: got accept=%0b wb=%0b, want 0 0", i, s_acc, s_wb);
      end
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, '0, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
      if (s_rv) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL illegal_result: got %0d result cycles, want 0", seen);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b;
    a = 32'h0101_0101; b = 32'h0202_0202;
    exp_push(3'b001, 2'd0, a, b, 5'd7);
    cyc(1, mk_instr(3'b001, 5'd7), 2'd0, a, b, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    cyc(0, '0, '0, '0, '0, 1, 2'd0, 0, s_acc, s_wb, s_rdy, s_rv);
    wait_drain("flush_pre");
    for (int k = 1; k < 4; k++)
      cyc(1, mk_instr(3'b001, 5'(k)), 2'(k), a, b, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    flush = 1'b1;
    cyc(1, mk_instr(3'b001, 5'd8), 2'd0, a, b, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    flush = 1'b0;
    checks++;
    if (s_rdy !== 1'b0 || s_acc !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue: got ready=%0b accept=%0b, want 0 0", s_rdy, s_acc);
    end
    cyc(0, '0, 2'd2, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    checks++;
    if (s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_slot_free: got ready=%0b, want 1", s_rdy);
    end
    exp_push(3'b010, 2'd1, '0, '0, 5'd11);
    cyc(1, mk_instr(3'b010, 5'd11), 2'd1, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    cyc(0, '0, '0, '0, '0, 1, 2'd1, 0, s_acc, s_wb, s_rdy, s_rv);
    wait_drain("flush_acc");
    idle(4);
  endtask

  task automatic test_async_reset();
    logic [31:0] a, b;
    a = 32'h0101_0101; b = 32'h0202_0202;
    result_ready = 1'b0;
    exp_push(3'b001, 2'd0, a, b, 5'd4);
    cyc(1, mk_instr(3'b001, 5'd4), 2'd0, a, b, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    cyc(0, '0, '0, '0, '0, 1, 2'd0, 0, s_acc, s_wb, s_rdy, s_rv);
    idle(1);
    #1;
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got result_valid=%0b, want 1", result_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1 || result_data !== 32'h0) begin
      errors++;
      $display("FAIL areset_now: got valid=%0b ready=%0b data=%h, want 0 1 0",
               result_valid, issue_ready, result_data);
    end
    sb_q.delete();
    acc_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    result_ready = 1'b1;
    idle(1);
    exp_push(3'b010, 2'd1, '0, '0, 5'd12);
    cyc(1, mk_instr(3'b010, 5'd12), 2'd1, '0, '0, 0, '0, 0, s_acc, s_wb, s_rdy, s_rv);
    cyc(0, '0, '0, '0, '0, 1, 2'd1, 0, s_acc, s_wb, s_rdy, s_rv);
    wait_drain("areset_acc");
  endtask

  initial begin
    checks = 0; errors = 0; acc_m = 0; hold_q = 1'b0;
    flush = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_id = '0;
    issue_rs1 = '0; issue_rs2 = '0; commit_valid = 1'b0; commit_id = '0;
    commit_kill = 1'b0; result_ready = 1'b1; rst_n = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_dotp_basic();
    test_dotpa_chain();
    test_kill();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
